// File: rtl/l1_cache_pkg.sv
// Shared types and block geometry for the direct-mapped L1 cache.
package l1_cache_pkg;

    localparam int unsigned BLOCK_W         = 128;
    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned OFFSET_W        = 2;
    localparam int unsigned WORD_W          = BLOCK_W / WORDS_PER_BLOCK;

    typedef enum logic [1:0] {
        COMPARE   = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

endpackage

// File: rtl/l1_cache_store.sv
// Valid/dirty/tag/data arrays: one combinational read port, one synchronous
// write port (single-word write or whole-block fill).
module l1_cache_store
    import l1_cache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 8,
    parameter int unsigned INDEX_W   = 3,
    parameter int unsigned TAG_W     = 25
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INDEX_W-1:0]  rd_index,
    output logic                rd_valid,
    output logic                rd_dirty,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [BLOCK_W-1:0]  rd_data,
    input  logic                word_we,
    input  logic [INDEX_W-1:0]  word_index,
    input  logic [OFFSET_W-1:0] word_offset,
    input  logic [WORD_W-1:0]   word_data,
    input  logic                fill_we,
    input  logic [INDEX_W-1:0]  fill_index,
    input  logic [TAG_W-1:0]    fill_tag,
    input  logic [BLOCK_W-1:0]  fill_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [BLOCK_W-1:0]   data_q [NUM_LINES];

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

    // Status bits: a fill makes the line clean, a word write makes it dirty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we) begin
            valid_q[fill_index] <= 1'b1;
            dirty_q[fill_index] <= 1'b0;
        end else if (word_we) begin
            dirty_q[word_index] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; valid gates every use.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[fill_index]  <= fill_tag;
            data_q[fill_index] <= fill_data;
        end else if (word_we) begin
            data_q[word_index][{word_offset, 5'd0} +: WORD_W] <= word_data;
        end
    end

endmodule

// File: rtl/l1_cache_dm.sv
// Direct-mapped, write-back, write-allocate L1 cache: compare/writeback/allocate
// FSM with registered memory-side request signals.
module l1_cache_dm
    import l1_cache_pkg::*;
#(
    parameter int unsigned NUM_LINES = 8,
    parameter int unsigned ADDR_W    = 30
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       proc_read,
    input  logic                       proc_write,
    input  logic [ADDR_W-1:0]          proc_addr,
    input  logic [WORD_W-1:0]          proc_wdata,
    output logic                       proc_stall,
    output logic [WORD_W-1:0]          proc_rdata,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [ADDR_W-OFFSET_W-1:0] mem_addr,
    output logic [BLOCK_W-1:0]         mem_wdata,
    input  logic                       mem_ready,
    input  logic [BLOCK_W-1:0]         mem_rdata
);

    localparam int unsigned INDEX_W = $clog2(NUM_LINES);
    localparam int unsigned BLK_W   = ADDR_W - OFFSET_W;
    localparam int unsigned TAG_W   = BLK_W - INDEX_W;

    state_t               state_q, state_n;
    logic [BLK_W-1:0]     req_blk_q, req_blk_n;
    logic                 mem_read_n, mem_write_n;
    logic [BLK_W-1:0]     mem_addr_n;
    logic [BLOCK_W-1:0]   mem_wdata_n;

    logic                 stall_c;
    logic [WORD_W-1:0]    rdata_c;
    logic                 word_we, fill_we;

    logic [INDEX_W-1:0]   req_index;
    logic [TAG_W-1:0]     req_tag;
    logic [OFFSET_W-1:0]  req_off;
    logic [BLK_W-1:0]     req_blk;
    logic                 req, hit;

    logic                 rd_valid, rd_dirty;
    logic [TAG_W-1:0]     rd_tag;
    logic [BLOCK_W-1:0]   rd_data;

    assign req_off   = proc_addr[OFFSET_W-1:0];
    assign req_index = proc_addr[OFFSET_W +: INDEX_W];
    assign req_tag   = proc_addr[ADDR_W-1 -: TAG_W];
    assign req_blk   = proc_addr[ADDR_W-1:OFFSET_W];
    assign req       = proc_read | proc_write;
    assign hit       = rd_valid & (rd_tag == req_tag);

    l1_cache_store #(
        .NUM_LINES (NUM_LINES),
        .INDEX_W   (INDEX_W),
        .TAG_W     (TAG_W)
    ) u_store (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_index    (req_index),
        .rd_valid    (rd_valid),
        .rd_dirty    (rd_dirty),
        .rd_tag      (rd_tag),
        .rd_data     (rd_data),
        .word_we     (word_we),
        .word_index  (req_index),
        .word_offset (req_off),
        .word_data   (proc_wdata),
        .fill_we     (fill_we),
        .fill_index  (req_blk_q[INDEX_W-1:0]),
        .fill_tag    (req_blk_q[BLK_W-1 -: TAG_W]),
        .fill_data   (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= COMPARE;
            req_blk_q <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_n;
            req_blk_q <= req_blk_n;
            mem_read  <= mem_read_n;
            mem_write <= mem_write_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        req_blk_n   = req_blk_q;
        mem_read_n  = mem_read;
        mem_write_n = mem_write;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        stall_c     = 1'b0;
        rdata_c     = '0;
        word_we     = 1'b0;
        fill_we     = 1'b0;

        unique case (state_q)
            COMPARE: begin
                if (req && hit) begin
                    if (proc_write) begin
                        word_we = 1'b1;
                    end else begin
                        rdata_c = rd_data[{req_off, 5'd0} +: WORD_W];
                    end
                end else if (req) begin
                    // Miss: the memory registers double as the victim latch.
                    stall_c   = 1'b1;
                    req_blk_n = req_blk;
                    if (rd_valid && rd_dirty) begin
                        state_n     = WRITEBACK;
                        mem_write_n = 1'b1;
                        mem_addr_n  = {rd_tag, req_index};
                        mem_wdata_n = rd_data;
                    end else begin
                        state_n    = ALLOCATE;
                        mem_read_n = 1'b1;
                        mem_addr_n = req_blk;
                    end
                end
            end
            WRITEBACK: begin
                stall_c = 1'b1;
                if (mem_ready) begin
                    state_n     = ALLOCATE;
                    mem_write_n = 1'b0;
                    mem_read_n  = 1'b1;
                    mem_addr_n  = req_blk_q;
                end
            end
            ALLOCATE: begin
                stall_c = 1'b1;
                if (mem_ready) begin
                    state_n    = COMPARE;
                    mem_read_n = 1'b0;
                    fill_we    = 1'b1;
                end
            end
            default: begin
                state_n     = COMPARE;
                mem_read_n  = 1'b0;
                mem_write_n = 1'b0;
            end
        endcase
    end

    assign proc_stall = stall_c;
    assign proc_rdata = rdata_c;

endmodule
